// File: rtl/combo_code_sender_if.sv
// A/B nibble-pair bus between the code sender and the combination checker.
// master: the sender (drives A/B, busy, done; receives start/abort).
// slave : the controller/checker side (drives start/abort; observes the rest).
//   start  request to send the programmed code
//   abort  synchronous abort back to idle
//   A, B   checker digits (4 bits each)
//   busy   sender is mid-sequence
//   done   one-cycle pulse on normal completion
interface combo_code_sender_if;
  logic       start;
  logic       abort;
  logic [3:0] A;
  logic [3:0] B;
  logic       busy;
  logic       done;

  modport master (
    input  start,
    input  abort,
    output A,
    output B,
    output busy,
    output done
  );

  modport slave (
    output start,
    output abort,
    input  A,
    input  B,
    input  busy,
    input  done
  );
endinterface

// File: rtl/combo_code_sender.sv
// combo_code_sender: drives a programmed three-pair code onto the A/B bus of
// the combination checker, holds the last pair so the checker shows its
// verdict, then returns the bus to 0/0 so the checker restarts.
//
// Ports:
//   clock    rising-edge clock
//   reset    asynchronous, active-high reset
//   corrupt  (only with COMBO_CODE_SENDER_CORRUPT_EN) flips B[0] of the third
//            pair; sampled on the start edge and held for the whole sequence
//   bus      combo_code_sender_if.master: start/abort in; A, B, busy, done out
//   step     current pair index 0..2; 3 in HOLD/DONE/IDLE
//   HS       active-low 7-segment digit showing step ("-" for 3)
//
// Optional feature macro: COMBO_CODE_SENDER_CORRUPT_EN.
// All outputs are registered; they are computed from the next state.
module combo_code_sender #(
  parameter logic [7:0]  CODE0       = 8'h28,
  parameter logic [7:0]  CODE1       = 8'h19,
  parameter logic [7:0]  CODE2       = 8'h96,
  parameter int unsigned STEP_CYCLES = 1,
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic                       clock,
  input  logic                       reset,
`ifdef COMBO_CODE_SENDER_CORRUPT_EN
  input  logic                       corrupt,
`endif
  combo_code_sender_if.master        bus,
  output logic [1:0]                 step,
  output logic [6:0]                 HS
);

  // Zero-length parameters are treated as one cycle.
  localparam int unsigned StepEff = (STEP_CYCLES == 0) ? 1 : STEP_CYCLES;
  localparam int unsigned HoldEff = (HOLD_CYCLES == 0) ? 1 : HOLD_CYCLES;
  localparam int unsigned MaxCyc  = (StepEff > HoldEff) ? StepEff : HoldEff;
  localparam int unsigned CntW    = (MaxCyc < 2) ? 1 : $clog2(MaxCyc);

  localparam logic [CntW-1:0] StepLoad = CntW'(StepEff - 1);
  localparam logic [CntW-1:0] HoldLoad = CntW'(HoldEff - 1);

  typedef enum logic [2:0] {
    StIdle,
    StSend0,
    StSend1,
    StSend2,
    StHold,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            corrupt_q, corrupt_d;
  logic [3:0]      a_q, a_d;
  logic [3:0]      b_q, b_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [1:0]      step_q, step_d;
  logic [6:0]      hs_q, hs_d;
  logic [3:0]      b_last;

  logic corrupt_in;
`ifdef COMBO_CODE_SENDER_CORRUPT_EN
  assign corrupt_in = corrupt;
`else
  assign corrupt_in = 1'b0;
`endif

  // Third pair's B digit, optionally with bit 0 flipped for negative tests.
  assign b_last = CODE2[3:0] ^ {3'b000, corrupt_q};

  // Next-state logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    corrupt_d = corrupt_q;
    if (bus.abort) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            state_d   = StSend0;
            cnt_d     = StepLoad;
            corrupt_d = corrupt_in;
          end
        end
        StSend0: begin
          if (cnt_q == '0) begin
            state_d = StSend1;
            cnt_d   = StepLoad;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        StSend1: begin
          if (cnt_q == '0) begin
            state_d = StSend2;
            cnt_d   = StepLoad;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        StSend2: begin
          if (cnt_q == '0) begin
            state_d = StHold;
            cnt_d   = HoldLoad;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        StHold: begin
          if (cnt_q == '0) begin
            state_d = StDone;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        StDone: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Output values for the state being entered; registered below.
  always_comb begin
    a_d    = 4'h0;
    b_d    = 4'h0;
    busy_d = 1'b1;
    done_d = 1'b0;
    step_d = 2'd3;
    unique case (state_d)
      StIdle: busy_d = 1'b0;
      StSend0: begin
        a_d    = CODE0[7:4];
        b_d    = CODE0[3:0];
        step_d = 2'd0;
      end
      StSend1: begin
        a_d    = CODE1[7:4];
        b_d    = CODE1[3:0];
        step_d = 2'd1;
      end
      StSend2: begin
        a_d    = CODE2[7:4];
        b_d    = b_last;
        step_d = 2'd2;
      end
      StHold: begin
        a_d = CODE2[7:4];
        b_d = b_last;
      end
      StDone:  done_d = 1'b1;
      default: busy_d = 1'b0;
    endcase
  end

  // Digit decode, then inverted for the active-low display.
  always_comb begin
    hs_d = ~7'h40;
    unique case (step_d)
      2'd0:    hs_d = ~7'h3F;
      2'd1:    hs_d = ~7'h06;
      2'd2:    hs_d = ~7'h5B;
      default: hs_d = ~7'h40;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      corrupt_q <= 1'b0;
      a_q       <= 4'h0;
      b_q       <= 4'h0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      step_q    <= 2'd3;
      hs_q      <= ~7'h40;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      corrupt_q <= corrupt_d;
      a_q       <= a_d;
      b_q       <= b_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      step_q    <= step_d;
      hs_q      <= hs_d;
    end
  end

  assign bus.A    = a_q;
  assign bus.B    = b_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign step     = step_q;
  assign HS       = hs_q;

endmodule

// File: tb/tb_combo_code_sender.sv
// Directed bench for combo_code_sender: default-parameter instance plus a
// STEP_CYCLES=3 / HOLD_CYCLES=2 instance, expectations written by hand.
module tb_combo_code_sender;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  combo_code_sender_if bus ();
  combo_code_sender_if bus3 ();

  logic [1:0] step, step3;
  logic [6:0] hs, hs3;
`ifdef COMBO_CODE_SENDER_CORRUPT_EN
  logic corrupt;
`endif

  combo_code_sender dut (
    .clock   (clock),
    .reset   (reset),
`ifdef COMBO_CODE_SENDER_CORRUPT_EN
    .corrupt (corrupt),
`endif
    .bus     (bus),
    .step    (step),
    .HS      (hs)
  );

  combo_code_sender #(
    .STEP_CYCLES (3),
    .HOLD_CYCLES (2)
  ) dut3 (
    .clock   (clock),
    .reset   (reset),
`ifdef COMBO_CODE_SENDER_CORRUPT_EN
    .corrupt (1'b0),
`endif
    .bus     (bus3),
    .step    (step3),
    .HS      (hs3)
  );

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // {busy, done, step, A, B}
  function automatic logic [11:0] mk(input logic bsy, input logic dn, input logic [1:0] st,
                                     input logic [3:0] a, input logic [3:0] b);
    return {bsy, dn, st, a, b};
  endfunction

  function automatic logic [11:0] obs();
    return {bus.busy, bus.done, step, bus.A, bus.B};
  endfunction

  function automatic logic [11:0] obs3();
    return {bus3.busy, bus3.done, step3, bus3.A, bus3.B};
  endfunction

  // Default instance, cycle i after the start edge (index 8 is the idle cycle).
  function automatic logic [11:0] exp_dflt(input int i);
    if (i == 0)      return mk(1'b1, 1'b0, 2'd0, 4'h2, 4'h8);
    else if (i == 1) return mk(1'b1, 1'b0, 2'd1, 4'h1, 4'h9);
    else if (i == 2) return mk(1'b1, 1'b0, 2'd2, 4'h9, 4'h6);
    else if (i < 7)  return mk(1'b1, 1'b0, 2'd3, 4'h9, 4'h6);
    else if (i == 7) return mk(1'b1, 1'b1, 2'd3, 4'h0, 4'h0);
    else             return mk(1'b0, 1'b0, 2'd3, 4'h0, 4'h0);
  endfunction

  function automatic logic [11:0] exp_slow(input int i);
    if (i < 3)       return mk(1'b1, 1'b0, 2'd0, 4'h2, 4'h8);
    else if (i < 6)  return mk(1'b1, 1'b0, 2'd1, 4'h1, 4'h9);
    else if (i < 9)  return mk(1'b1, 1'b0, 2'd2, 4'h9, 4'h6);
    else if (i < 11) return mk(1'b1, 1'b0, 2'd3, 4'h9, 4'h6);
    else if (i == 11) return mk(1'b1, 1'b1, 2'd3, 4'h0, 4'h0);
    else             return mk(1'b0, 1'b0, 2'd3, 4'h0, 4'h0);
  endfunction

  // Active-low segments for steps 0..3.
  function automatic logic [6:0] exp_hs(input int i);
    if (i == 0)      return 7'h40;
    else if (i == 1) return 7'h79;
    else if (i == 2) return 7'h24;
    else             return 7'h3F;
  endfunction

  task automatic drain(input string tag);
    int n = 0;
    while (bus.busy && n < 30) begin
      tick();
      n++;
    end
    check_eq(tag, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    logic seen;
    reset      = 1'b1;
    bus.start  = 1'b0;
    bus.abort  = 1'b0;
    bus3.start = 1'b0;
    bus3.abort = 1'b0;
`ifdef COMBO_CODE_SENDER_CORRUPT_EN
    corrupt = 1'b0;
`endif
    #2;
    check_eq("rst_state", 32'(obs()), 32'(mk(1'b0, 1'b0, 2'd3, 4'h0, 4'h0)));
    check_eq("rst_hs", 32'(hs), 32'h3F);
    #20;
    reset = 1'b0;
    tick();
    check_eq("idle_after_rst", 32'(obs()), 32'(mk(1'b0, 1'b0, 2'd3, 4'h0, 4'h0)));

    // Default sequence from a one-cycle start pulse.
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      check_eq($sformatf("dflt[%0d]", i), 32'(obs()), 32'(exp_dflt(i)));
      if (i < 4) check_eq($sformatf("dflt_hs[%0d]", i), 32'(hs), 32'(exp_hs(i)));
      tick();
    end

    // Stretched steps and hold.
    bus3.start = 1'b1;
    tick();
    bus3.start = 1'b0;
    for (int i = 0; i < 13; i++) begin
      check_eq($sformatf("slow[%0d]", i), 32'(obs3()), 32'(exp_slow(i)));
      tick();
    end

    // abort together with start in IDLE stays idle.
    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check_eq("abort_start_idle", 32'(obs()), 32'(mk(1'b0, 1'b0, 2'd3, 4'h0, 4'h0)));

    // Abort during SEND1.
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check_eq("ab_send0", 32'(obs()), 32'(exp_dflt(0)));
    tick();
    check_eq("ab_send1", 32'(obs()), 32'(exp_dflt(1)));
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check_eq("ab_idle", 32'(obs()), 32'(mk(1'b0, 1'b0, 2'd3, 4'h0, 4'h0)));
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      seen = seen | bus.done | bus.busy;
      tick();
    end
    check_eq("ab_quiet", 32'(seen), 32'd0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check_eq("ab_restart", 32'(obs()), 32'(exp_dflt(0)));
    drain("ab_drain");
    tick();

    // start held high: one idle cycle between back-to-back sequences.
    bus.start = 1'b1;
    tick();
    for (int i = 0; i < 19; i++) begin
      check_eq($sformatf("held[%0d]", i), 32'(obs()), 32'(exp_dflt(i % 9)));
      tick();
    end
    bus.start = 1'b0;
    drain("held_drain");
    tick();

    // Async reset between edges during SEND2.
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    check_eq("ar_send2", 32'(obs()), 32'(exp_dflt(2)));
    #2;
    reset = 1'b1;
    #1;
    check_eq("ar_state", 32'(obs()), 32'(mk(1'b0, 1'b0, 2'd3, 4'h0, 4'h0)));
    check_eq("ar_hs", 32'(hs), 32'h3F);
    #3;
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      seen = seen | bus.busy | bus.done | (|bus.A) | (|bus.B);
    end
    check_eq("ar_quiet", 32'(seen), 32'd0);

`ifdef COMBO_CODE_SENDER_CORRUPT_EN
    corrupt   = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    corrupt   = 1'b0;
    check_eq("cor_send0", 32'(obs()), 32'(exp_dflt(0)));
    tick();
    check_eq("cor_send1", 32'(obs()), 32'(exp_dflt(1)));
    tick();
    check_eq("cor_send2", 32'(obs()), 32'(mk(1'b1, 1'b0, 2'd2, 4'h9, 4'h7)));
    tick();
    check_eq("cor_hold", 32'(obs()), 32'(mk(1'b1, 1'b0, 2'd3, 4'h9, 4'h7)));
    drain("cor_drain");
    tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    check_eq("nocor_send2", 32'(obs()), 32'(exp_dflt(2)));
    drain("nocor_drain");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
